// File: rtl/commit_trace_buffer.sv
// rtl/commit_trace_buffer.sv - retire-trace FIFO with drop/overwrite full policy and saturating statistics
module commit_trace_buffer #(
  parameter int DEPTH     = 16,
  parameter int OVERWRITE = 0,
  parameter int CNT_W     = 32,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             commit,
  input  logic [31:0]      commit_pc,
  input  logic [31:0]      commit_instr,
  input  logic [31:0]      commit_next_pc,
  input  logic [31:0]      commit_pred_pc,
  input  logic             freeze,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_instr,
  output logic [31:0]      out_next_pc,
  output logic             out_mispred,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic [CNT_W-1:0] commit_cnt,
  output logic [CNT_W-1:0] mispred_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  typedef enum logic [1:0] {S_EMPTY, S_PARTIAL, S_FULL} state_e;

  localparam logic [AW:0]      DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam bit               OVW     = (OVERWRITE != 0);

  // Entry layout: {pc, instr, next_pc, mispred}
  logic [96:0]      mem_q [DEPTH];
  logic [96:0]      head;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  state_e           state_q, state_d;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] commit_cnt_q, commit_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic accept, mispred, pop, drop, ovw, push;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != CNT_MAX)) ? v + CNT_W'(1) : v;
  endfunction

  // Classify this cycle: accept, pop, and what a full buffer does with the accept
  always_comb begin
    accept  = commit & ~freeze & ~clr;
    mispred = (commit_next_pc != commit_pred_pc);
    pop     = (state_q != S_EMPTY) & out_ready & ~clr;
    drop    = accept & (state_q == S_FULL) & ~pop;
    ovw     = drop & OVW;
    push    = accept & ((state_q != S_FULL) | pop | OVW);
  end

  // Next pointers, occupancy, sticky flag and counters; clr wins over everything
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    overflow_d    = overflow_q;
    commit_cnt_d  = commit_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    drop_cnt_d    = drop_cnt_q;
    if (clr) begin
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      count_d       = '0;
      overflow_d    = 1'b0;
      commit_cnt_d  = '0;
      mispred_cnt_d = '0;
      drop_cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      // An overwrite retires the oldest entry, so the read side moves with it
      if (pop | ovw) rd_ptr_d = rd_ptr_q + AW'(1);
      if (push & ~pop & ~ovw) count_d = count_q + (AW+1)'(1);
      else if (pop & ~push)   count_d = count_q - (AW+1)'(1);
      if (drop) overflow_d = 1'b1;
      commit_cnt_d  = sat_inc(commit_cnt_q, accept);
      mispred_cnt_d = sat_inc(mispred_cnt_q, accept & mispred);
      drop_cnt_d    = sat_inc(drop_cnt_q, drop);
    end
  end

  // Buffer state follows the next occupancy so it always matches count_q
  always_comb begin
    state_d = S_PARTIAL;
    if (count_d == '0)          state_d = S_EMPTY;
    else if (count_d == DEPTH_C) state_d = S_FULL;
  end

  // Control registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      state_q       <= S_EMPTY;
      overflow_q    <= 1'b0;
      commit_cnt_q  <= '0;
      mispred_cnt_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      state_q       <= state_d;
      overflow_q    <= overflow_d;
      commit_cnt_q  <= commit_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  // Entry storage is not reset; contents only matter behind a valid read pointer
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {commit_pc, commit_instr, commit_next_pc, mispred};
  end

  assign head        = mem_q[rd_ptr_q];
  assign out_valid   = (state_q != S_EMPTY);
  assign out_pc      = head[96:65];
  assign out_instr   = head[64:33];
  assign out_next_pc = head[32:1];
  assign out_mispred = head[0];
  assign count       = count_q;
  assign full        = (state_q == S_FULL);
  assign empty       = (state_q == S_EMPTY);
  assign overflow    = overflow_q;
  assign commit_cnt  = commit_cnt_q;
  assign mispred_cnt = mispred_cnt_q;
  assign drop_cnt    = drop_cnt_q;

endmodule
